mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-bit 2:1 mux output channel between two requesters (A and B). It chooses a winner each cycle and drives the mux select. The winning operand is captured into a registered output stage with a valid/ready handshake, so downstream logic sees one arbitrated stream. It sits in front of the two-input mux datapath and owns its `sel` line.

---
 rtl/mux_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two requesters feeding a registered valid/ready output stage.
// Optional burst mode (macro ARB_BURST_EN) lets an owner keep winning ties for up to BURST_LEN beats.
module mux_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             load_s;
  logic             win_b_s;

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same_owner_s;

  // Winner selection: the owner keeps ties until its burst budget is spent.
  always_comb begin
    win_b_s = 1'b0;
    if (req_a && !req_b) begin
      win_b_s = 1'b0;
    end else if (!req_a && req_b) begin
      win_b_s = 1'b1;
    end else if (req_a && req_b) begin
      case (owner_q)
        OWN_A:   win_b_s = (cnt_q >= CNT_MAX);
        OWN_B:   win_b_s = (cnt_q < CNT_MAX);
        IDLE:    win_b_s = 1'b0;
        default: win_b_s = 1'b0;
      endcase
    end else begin
      win_b_s = 1'b0;
    end
  end

  // Burst counter: saturating on repeat wins, reloads to 1 on an owner change.
  always_comb begin
    cnt_d        = cnt_q;
    same_owner_s = (win_b_s && (owner_q == OWN_B)) || (!win_b_s && (owner_q == OWN_A));
    if (load_s) begin
      if (same_owner_s) begin
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        cnt_d = CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_burst_len = BURST_LEN;

  // Winner selection: ties go to the requester that did not win last (IDLE acts like OWN_B).
  always_comb begin
    win_b_s = 1'b0;
    if (req_a && !req_b) begin
      win_b_s = 1'b0;
    end else if (!req_a && req_b) begin
      win_b_s = 1'b1;
    end else if (req_a && req_b) begin
      win_b_s = (owner_q == OWN_A);
    end else begin
      win_b_s = 1'b0;
    end
  end
`endif

  // Load decision, grants and next state of the output stage and owner.
  always_comb begin
    load_s  = (req_a | req_b) & (~valid_q | out_ready);
    gnt_a   = load_s & ~win_b_s & ~rst;
    gnt_b   = load_s & win_b_s & ~rst;
    owner_d = owner_q;
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (load_s) begin
      owner_d = win_b_s ? OWN_B : OWN_A;
      out_d   = win_b_s ? b : a;
      sel_d   = win_b_s;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset clears the output stage immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= IDLE;
      out_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (default, non-burst build): vector table,
// async-reset sequence and randomized run against a behavioural model.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, out_ready;
  logic [3:0] a, b;
  logic       gnt_a, gnt_b, sel, out_valid;
  logic [3:0] out;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.WIDTH(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a(a), .req_b(req_b), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .out(out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ra;
    logic [3:0] a;
    logic       rb;
    logic [3:0] b;
    logic       rdy;
    logic       ga;
    logic       gb;
    logic       v;
    logic [3:0] o;
    logic       s;
  } vec_t;

  vec_t tbl[16];

  // Behavioural model: who won last, plus the contents of the output register.
  bit       m_last_was_b;
  bit       m_valid;
  bit [3:0] m_data;
  bit       m_sel;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_was_b = 1'b1;
    m_valid      = 1'b0;
    m_data       = 4'd0;
    m_sel        = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 4'd0; b = 4'd0; out_ready = 1'b0;

    //          rst   ra    a      rb    b      rdy   ga    gb    v     out    sel
    tbl[0]  = '{1'b1, 1'b1, 4'd13, 1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'd13, 1'b0, 4'd7,  1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'd13, 1'b0, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'd3,  1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, 4'd11, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'd3,  1'b1, 4'd11, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'd3,  1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, 4'd11, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'd10, 1'b1, 4'd11, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'd10, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'd10, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'd10, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'd10, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1, 4'd7,  1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'd10, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'd7,  1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'd10, 1'b0, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 4'd7,  1'b1};
    tbl[13] = '{1'b1, 1'b1, 4'd3,  1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'd3,  1'b1, 4'd11, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'd3,  1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, 4'd11, 1'b1};

    #12;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; req_a = tbl[i].ra; a = tbl[i].a;
      req_b = tbl[i].rb; b = tbl[i].b; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d gnt_a", i), int'(gnt_a), int'(tbl[i].ga));
      chk($sformatf("vec%0d gnt_b", i), int'(gnt_b), int'(tbl[i].gb));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(tbl[i].v));
      chk($sformatf("vec%0d out", i), int'(out), int'(tbl[i].o));
      chk($sformatf("vec%0d sel", i), int'(sel), int'(tbl[i].s));
    end

    // Asynchronous reset while a beat (11, from B) is held under backpressure.
    @(negedge clk);
    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b0;
    #1;
    chk("pre_rst out_valid", int'(out_valid), 1);
    chk("pre_rst out", int'(out), 11);
    rst = 1'b1;
    #1;
    chk("async_rst out_valid", int'(out_valid), 0);
    chk("async_rst out", int'(out), 0);
    chk("async_rst sel", int'(sel), 0);
    chk("async_rst gnt_a", int'(gnt_a), 0);
    chk("async_rst gnt_b", int'(gnt_b), 0);
    @(negedge clk);
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
    model_reset();

    // Randomized run against the model; operands stay stable while a request waits.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit       exp_load, exp_win_b, exp_ga, exp_gb;
      bit       pend_a, pend_b;
      pend_a = req_a && !gnt_a;
      pend_b = req_b && !gnt_b;
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      if (!pend_a || rst) begin
        req_a = ($urandom_range(0, 2) != 0);
        a     = 4'($urandom);
      end
      if (!pend_b || rst) begin
        req_b = ($urandom_range(0, 2) != 0);
        b     = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (rst) model_reset();
      #1;
      exp_load  = !rst && (req_a || req_b) && (!m_valid || out_ready);
      exp_win_b = req_b && (!req_a || !m_last_was_b);
      exp_ga    = exp_load && !exp_win_b;
      exp_gb    = exp_load && exp_win_b;
      chk("rand gnt_a", int'(gnt_a), int'(exp_ga));
      chk("rand gnt_b", int'(gnt_b), int'(exp_gb));
      @(posedge clk);
      if (exp_load) begin
        m_data       = exp_win_b ? b : a;
        m_sel        = exp_win_b;
        m_valid      = 1'b1;
        m_last_was_b = exp_win_b;
      end else if (!rst && m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      #1;
      chk("rand out_valid", int'(out_valid), int'(m_valid));
      chk("rand out", int'(out), int'(m_data));
      chk("rand sel", int'(sel), int'(m_sel));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
